// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first, through a single
// full-subtractor cell with a registered borrow, behind a start/busy/done handshake.
module serial_sub #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            br_q, br_d;
    logic            bout_q, bout_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            cell_x, cell_y, cell_d, cell_bo;

    assign cell_x  = a_q[0];
    assign cell_y  = b_q[0];
    assign cell_d  = cell_x ^ cell_y ^ br_q;
    assign cell_bo = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & br_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d          = a_q >> 1;
                b_d          = b_q >> 1;
                res_d        = res_q >> 1;
                res_d[W-1]   = cell_d;
                br_d         = cell_bo;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = StDone;
                    diff_d  = res_d;
                    bout_d  = cell_bo;
                end
            end
            StDone: begin
                state_d = start ? StShift : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Operand load shares one path for the idle accept and the back-to-back accept in DONE.
        if ((state_q == StIdle || state_q == StDone) && start) begin
            a_d   = a;
            b_d   = b;
            br_d  = bin;
            res_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed table, exhaustive 4-bit sweep, streaming with
// random ignored starts, reset abort, and a 1-bit instance.
module tb_serial_sub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a, b;
    logic       bin;
    logic       busy, done;
    logic [3:0] diff;
    logic       bout;

    logic       start1;
    logic [0:0] a1, b1;
    logic       bin1;
    logic       busy1, done1;
    logic [0:0] diff1;
    logic       bout1;

    int n_cmp = 0;
    int n_err = 0;

    serial_sub #(.W(4), .CW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    serial_sub #(.W(1), .CW(6)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic       vbin;
        logic [3:0] ediff;
        logic       ebout;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, borrow is the sign of the full difference.
    function automatic logic [4:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                         input logic mbin);
        int r;
        r = int'(ma) - int'(mb) - int'(mbin);
        return {(r < 0), r[3:0]};
    endfunction

    // One operation from idle: checks busy span, latency W, result, single-cycle done, hold.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic tbin,
                          input logic [3:0] ed, input logic eb, input string nm);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, 4);
        chk({nm, " busy span"}, int'(busy_ok), 1);
        chk({nm, " busy at done"}, int'(busy), 0);
        chk({nm, " diff"}, int'(diff), int'(ed));
        chk({nm, " bout"}, int'(bout), int'(eb));
        @(negedge clk);
        chk({nm, " done width"}, int'(done), 0);
        chk({nm, " diff hold"}, int'(diff), int'(ed));
    endtask

    vec_t       vecs[6];
    logic [4:0] q[$];
    logic [4:0] m;
    int         gap, got, guard;

    initial begin
        vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
        vecs[1] = '{4'd3,  4'd9,  1'b0, 4'd10, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd5,  4'd5,  1'b0, 4'd0,  1'b0};
        vecs[4] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};
        vecs[5] = '{4'd0,  4'd15, 1'b1, 4'd0,  1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset diff", int'(diff), 0);
        chk("reset bout", int'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, vecs[i].ediff, vecs[i].ebout, "table");

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    m = model(4'(ia), 4'(ib), 1'(ic));
                    run_op(4'(ia), 4'(ib), 1'(ic), m[3:0], m[4], "sweep");
                end

        // Streaming: start held in every DONE cycle, random starts/operands while busy.
        @(negedge clk);
        a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom); start = 1'b1;
        q.push_back(model(a, b, bin));
        gap = 0; got = 0; guard = 0;
        while (got < 40 && guard < 1000) begin
            @(negedge clk);
            guard++;
            gap++;
            if (done) begin
                if (q.size() > 0) begin
                    chk("stream diff", int'(diff), int'(q[0][3:0]));
                    chk("stream bout", int'(bout), int'(q[0][4]));
                    void'(q.pop_front());
                end
                chk("stream period", gap, 5);
                got++;
                gap = 0;
                a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
                if (got < 40) begin
                    start = 1'b1;
                    q.push_back(model(a, b, bin));
                end else begin
                    start = 1'b0;
                end
            end else begin
                chk("stream busy", int'(busy), 1);
                a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
                start = 1'($urandom);
            end
        end
        chk("stream count", got, 40);
        start = 1'b0;
        @(negedge clk);
        chk("stream idle", int'(busy), 0);

        // Reset abort after two SHIFT edges.
        run_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, "pre-abort");
        @(negedge clk);
        a = 4'd12; b = 4'd7; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort diff", int'(diff), 0);
        chk("abort bout", int'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort no done", int'(done), 0);
        run_op(4'd7, 4'd12, 1'b0, 4'd11, 1'b1, "post-abort");

        // 1-bit instance: one SHIFT cycle then DONE.
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1 busy", int'(busy1), 1);
        chk("w1 early done", int'(done1), 0);
        @(negedge clk);
        chk("w1 done", int'(done1), 1);
        chk("w1 busy at done", int'(busy1), 0);
        chk("w1 diff", int'(diff1), 1);
        chk("w1 bout", int'(bout1), 1);
        @(negedge clk);
        chk("w1 done width", int'(done1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    always @(negedge clk) begin
        if (rst_n && busy && done) begin
            n_cmp++;
            n_err++;
            $display("FAIL busy/done overlap: got busy=1 done=1 required not both");
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish required finish before time limit");
        $fatal(1);
    end

endmodule
